nn_layer_folded: RTL

//  Time-multiplexed fully-connected layer: NUM_PE MAC lanes serve NUM_NEURONS neurons in NUM_NEURONS/NUM_PE groups.

---
 rtl/nn_layer_folded_if.sv | 43 ++++
 rtl/nn_layer_folded.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/nn_layer_folded_if.sv
// Bundle of the streaming and weight-RAM signals of nn_layer_folded.
//   slave  : the layer itself (consumes activations and weights, produces results)
//   master : the surrounding environment (activation source, weight RAM, result sink)
// Signals:
//   in_valid/in_ready/in_data        activation stream into the layer
//   w_rd_en/w_addr/w_data            synchronous weight RAM port (data one cycle after enable)
//   out_valid/out_ready/out_data     one group of requantized neuron outputs per beat
//   out_group/out_last               group index of the beat, final-group marker
//   busy                             layer is computing or holding a result
interface nn_layer_folded_if #(
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 128,
    parameter int NUM_PE      = 8,
    parameter int DATA_W      = 4,
    parameter int WEIGHT_W    = 4
);
    localparam int NUM_GROUPS = NUM_NEURONS / NUM_PE;
    localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int ADDR_W     = $clog2(NUM_GROUPS * NUM_INPUTS);

    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_data;
    logic                       w_rd_en;
    logic [ADDR_W-1:0]          w_addr;
    logic [NUM_PE*WEIGHT_W-1:0] w_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_PE*DATA_W-1:0]   out_data;
    logic [GRP_W-1:0]           out_group;
    logic                       out_last;
    logic                       busy;

    modport master (
        output in_valid, in_data, w_data, out_ready,
        input  in_ready, w_rd_en, w_addr, out_valid, out_data, out_group, out_last, busy
    );

    modport slave (
        input  in_valid, in_data, w_data, out_ready,
        output in_ready, w_rd_en, w_addr, out_valid, out_data, out_group, out_last, busy
    );
endinterface

// File: rtl/nn_layer_folded.sv
// Time-multiplexed fully-connected layer. One activation vector is buffered from
// the input stream, then replayed once per group of NUM_PE neurons; each lane
// multiplies the unsigned activation by its signed weight from the external RAM
// and accumulates. Each finished group is shifted, ReLU'd and saturated to DATA_W
// bits and emitted as one beat.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous reset, active-low
//   bus  nn_layer_folded_if.slave: activation stream in, weight RAM port,
//        result stream out (with group index / last flag), busy
module nn_layer_folded #(
    parameter int NUM_INPUTS  = 784,
    parameter int NUM_NEURONS = 128,
    parameter int NUM_PE      = 8,
    parameter int DATA_W      = 4,
    parameter int WEIGHT_W    = 4,
    parameter int ACC_W       = 24,
    parameter int SHIFT       = 6
) (
    input logic              clk,
    input logic              rst,
    nn_layer_folded_if.slave bus
);
    localparam int NUM_GROUPS = NUM_NEURONS / NUM_PE;
    localparam int IDX_W      = $clog2(NUM_INPUTS);
    localparam int GRP_W      = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int ADDR_W     = $clog2(NUM_GROUPS * NUM_INPUTS);
    localparam int PROD_W     = DATA_W + 1 + WEIGHT_W;

    localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(NUM_INPUTS - 1);
    localparam logic [GRP_W-1:0]        LAST_GRP   = GRP_W'(NUM_GROUPS - 1);
    localparam logic [ADDR_W-1:0]       GRP_STRIDE = ADDR_W'(NUM_INPUTS);
    localparam logic signed [ACC_W-1:0] ACT_MAX    = ACC_W'((1 << DATA_W) - 1);

    localparam logic [1:0] S_LOAD    = 2'd0;
    localparam logic [1:0] S_COMPUTE = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_EMIT    = 2'd3;

    logic [1:0]               state;
    logic [IDX_W-1:0]         idx;
    logic [GRP_W-1:0]         group;
    logic [ADDR_W-1:0]        base_addr;
    logic [DATA_W-1:0]        act_buf [NUM_INPUTS];
    logic [DATA_W-1:0]        x_p1;
    logic                     vld_p1;
    logic signed [ACC_W-1:0]  acc [NUM_PE];
    logic                     in_ready_r;
    logic                     out_valid_r;
    logic                     out_last_r;
    logic [GRP_W-1:0]         out_group_r;
    logic [NUM_PE*DATA_W-1:0] out_data_r;

    logic accept;
    logic issue;

    // acc + {0,x} * w with the product sign-extended to the accumulator width;
    // the sum wraps modulo 2^ACC_W.
    function automatic logic signed [ACC_W-1:0] mac(
        input logic signed [ACC_W-1:0]    a,
        input logic        [DATA_W-1:0]   x,
        input logic signed [WEIGHT_W-1:0] w
    );
        logic signed [PROD_W-1:0] xs;
        logic signed [PROD_W-1:0] ws;
        logic signed [PROD_W-1:0] prod;
        xs   = $signed({{WEIGHT_W{1'b0}}, 1'b0, x});
        ws   = $signed({{(DATA_W + 1){w[WEIGHT_W-1]}}, w});
        prod = xs * ws;
        return a + {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    endfunction

    // Arithmetic shift, then clamp to [0, 2^DATA_W-1].
    function automatic logic [DATA_W-1:0] requant(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] y;
        y = a >>> SHIFT;
        if (y[ACC_W-1])
            return '0;
        else if (y > ACT_MAX)
            return '1;
        else
            return y[DATA_W-1:0];
    endfunction

    assign accept = bus.in_valid & in_ready_r;
    assign issue  = (state == S_COMPUTE);

    assign bus.in_ready  = in_ready_r;
    assign bus.w_rd_en   = issue;
    assign bus.w_addr    = issue ? (base_addr + ADDR_W'(idx)) : '0;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_group = out_group_r;
    assign bus.out_last  = out_last_r;
    assign bus.busy      = (state != S_LOAD);

    // Activation buffer and the p1 operand register: pure data, no reset needed.
    // buf[idx] is captured on the issue edge so it lines up with w_data, which
    // the RAM returns one cycle after the read enable.
    always_ff @(posedge clk) begin
        if (accept)
            act_buf[idx] <= bus.in_data;
        if (issue)
            x_p1 <= act_buf[idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_LOAD;
            idx         <= '0;
            group       <= '0;
            base_addr   <= '0;
            in_ready_r  <= 1'b0;
            vld_p1      <= 1'b0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_group_r <= '0;
            out_data_r  <= '0;
            for (int p = 0; p < NUM_PE; p++)
                acc[p] <= '0;
        end else begin
            // ---- p1 -> accumulate: operand pair issued last cycle ----
            vld_p1 <= issue;
            if (vld_p1) begin
                for (int p = 0; p < NUM_PE; p++)
                    acc[p] <= mac(acc[p], x_p1,
                                  $signed(bus.w_data[p*WEIGHT_W +: WEIGHT_W]));
            end

            case (state)
                S_LOAD: begin
                    in_ready_r <= 1'b1;
                    if (accept) begin
                        if (idx == LAST_IDX) begin
                            in_ready_r <= 1'b0;
                            idx        <= '0;
                            group      <= '0;
                            base_addr  <= '0;
                            for (int p = 0; p < NUM_PE; p++)
                                acc[p] <= '0;
                            state      <= S_COMPUTE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end

                S_COMPUTE: begin
                    if (idx == LAST_IDX) begin
                        idx   <= '0;
                        state <= S_DRAIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end

                // The final product lands in acc on the edge leaving DRAIN.
                S_DRAIN: begin
                    state <= S_EMIT;
                end

                // First EMIT cycle registers the requantized result; afterwards
                // the beat is held until the sink takes it.
                S_EMIT: begin
                    if (!out_valid_r) begin
                        out_valid_r <= 1'b1;
                        out_group_r <= group;
                        out_last_r  <= (group == LAST_GRP);
                        for (int p = 0; p < NUM_PE; p++)
                            out_data_r[p*DATA_W +: DATA_W] <= requant(acc[p]);
                    end else if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        if (out_last_r) begin
                            in_ready_r <= 1'b1;
                            state      <= S_LOAD;
                        end else begin
                            group     <= group + 1'b1;
                            base_addr <= base_addr + GRP_STRIDE;
                            idx       <= '0;
                            for (int p = 0; p < NUM_PE; p++)
                                acc[p] <= '0;
                            state     <= S_COMPUTE;
                        end
                    end
                end

                default: state <= S_LOAD;
            endcase
        end
    end
endmodule
